// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: picks the next fetch address, flushes wrong-path slots on
// taken control transfers, and halts on ecall or misaligned control-transfer targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic [6:0]  ex_opcode_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_rs1_i,
  input  logic        ex_br_taken_i,
  input  logic        resume_i,
  output logic [31:0] pc_o,
  output logic        if_valid_o,
  output logic        flush_o,
  output logic [31:0] link_o,
  output logic        halted_o,
  output logic        misalign_o,
  output logic [31:0] redirect_cnt_o
);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] cnt_q, cnt_d;

  logic        is_branch, is_jal, is_jalr, is_system;
  logic [31:0] target;
  logic [31:0] link;
  logic        redirect_req, trap_req, misalign_trap;

  always_comb begin
    is_branch = (ex_opcode_i == OpBranch);
    is_jal    = (ex_opcode_i == OpJal);
    is_jalr   = (ex_opcode_i == OpJalr);
    is_system = (ex_opcode_i == OpSystem);
    link      = ex_pc_i + 32'd4;

    if (is_jalr) begin
      target = (ex_rs1_i + ex_imm_i) & ~32'h1;
    end else begin
      target = ex_pc_i + ex_imm_i;
    end

    redirect_req  = ex_valid_i & (is_jal | is_jalr | (is_branch & ex_br_taken_i));
    // A redirect to a non-word-aligned target becomes a trap instead of a redirect.
    misalign_trap = redirect_req & target[1];
    trap_req      = ex_valid_i & (is_system | misalign_trap);
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    flush_o    = 1'b0;

    unique case (state_q)
      StRun: begin
        flush_o = redirect_req | trap_req;
        if (trap_req) begin
          pc_d       = link;
          state_d    = StHalt;
          if_valid_d = 1'b0;
          if (misalign_trap) begin
            misalign_d = 1'b1;
          end
        end else if (redirect_req) begin
          pc_d  = target;
          cnt_d = cnt_q + 32'd1;
        end else if (!stall_i) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StHalt: begin
        // Everything from EX is ignored; fetch restarts at the held PC.
        if (resume_i) begin
          state_d    = StRun;
          if_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b1;
      misalign_q <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_o           = pc_q;
  assign if_valid_o     = if_valid_q;
  assign link_o         = link;
  assign halted_o       = (state_q == StHalt);
  assign misalign_o     = misalign_q;
  assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, async-reset sequence, then random
// stimulus checked against a behavioural model.
module tb_pc_sequencer;

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpNop    = 7'b0010011;
  localparam logic [6:0] OpAlu    = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, ex_valid_i, ex_br_taken_i, resume_i;
  logic [6:0]  ex_opcode_i;
  logic [31:0] ex_pc_i, ex_imm_i, ex_rs1_i;
  logic [31:0] pc_o, link_o, redirect_cnt_o;
  logic        if_valid_o, flush_o, halted_o, misalign_o;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .ex_valid_i    (ex_valid_i),
    .ex_opcode_i   (ex_opcode_i),
    .ex_pc_i       (ex_pc_i),
    .ex_imm_i      (ex_imm_i),
    .ex_rs1_i      (ex_rs1_i),
    .ex_br_taken_i (ex_br_taken_i),
    .resume_i      (resume_i),
    .pc_o          (pc_o),
    .if_valid_o    (if_valid_o),
    .flush_o       (flush_o),
    .link_o        (link_o),
    .halted_o      (halted_o),
    .misalign_o    (misalign_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        tkn;
    logic        resume;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_halt;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_mis;
  logic [31:0] m_cnt;

  function automatic vec_t mk(input logic stall, input logic valid, input logic [6:0] op,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic tkn, input logic resume,
                              input logic e_flush, input logic [31:0] e_pc,
                              input logic e_halt, input logic e_mis, input logic [31:0] e_cnt);
    vec_t v;
    v.stall = stall; v.valid = valid; v.op = op; v.pc = pc; v.imm = imm; v.rs1 = rs1;
    v.tkn = tkn; v.resume = resume; v.e_flush = e_flush; v.e_pc = e_pc;
    v.e_halt = e_halt; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_i       = v.stall;
    ex_valid_i    = v.valid;
    ex_opcode_i   = v.op;
    ex_pc_i       = v.pc;
    ex_imm_i      = v.imm;
    ex_rs1_i      = v.rs1;
    ex_br_taken_i = v.tkn;
    resume_i      = v.resume;
  endtask

  // Apply one vector: check combinational outputs mid-cycle, then registered ones after the edge.
  task automatic step(input vec_t v);
    drive(v);
    #2;
    chk("flush", {31'd0, flush_o}, {31'd0, v.e_flush});
    chk("link", link_o, v.pc + 32'd4);
    @(posedge clk);
    #1;
    chk("pc", pc_o, v.e_pc);
    chk("if_valid", {31'd0, if_valid_o}, {31'd0, !v.e_halt});
    chk("halted", {31'd0, halted_o}, {31'd0, v.e_halt});
    chk("misalign", {31'd0, misalign_o}, {31'd0, v.e_mis});
    chk("redirect_cnt", redirect_cnt_o, v.e_cnt);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
  endtask

  // Advances the model by one edge; returns the flush expected during that cycle.
  function automatic logic model_step(input vec_t v);
    logic [31:0] tgt;
    logic        ctl, redir, trap;
    if (m_halted) begin
      if (v.resume) m_halted = 1'b0;
      return 1'b0;
    end
    tgt   = (v.op == OpJalr) ? ((v.rs1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
    ctl   = (v.op == OpJal) || (v.op == OpJalr) || (v.op == OpBranch && v.tkn);
    redir = v.valid && ctl;
    trap  = v.valid && ((v.op == OpSystem) || (redir && tgt[1]));
    if (trap) begin
      m_pc     = v.pc + 32'd4;
      m_halted = 1'b1;
      if (redir && tgt[1]) m_mis = 1'b1;
    end else if (redir) begin
      m_pc  = tgt;
      m_cnt = m_cnt + 32'd1;
    end else if (!v.stall) begin
      m_pc = m_pc + 32'd4;
    end
    return redir || trap;
  endfunction

  vec_t tbl[21];
  vec_t idle;

  initial begin
    idle = mk(0, 0, OpNop, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = mk(0, 0, OpNop, 0, 0, 0, 0, 0,                    0, 32'h4, 0, 0, 0);
    tbl[1]  = mk(0, 0, OpNop, 0, 0, 0, 0, 0,                    0, 32'h8, 0, 0, 0);
    tbl[2]  = mk(0, 0, OpNop, 0, 0, 0, 0, 0,                    0, 32'hC, 0, 0, 0);
    tbl[3]  = mk(1, 1, OpBranch, 32'h100, 32'hFFFF_FFF0, 0, 1, 0, 1, 32'hF0, 0, 0, 1);
    tbl[4]  = mk(1, 1, OpBranch, 32'h100, 32'hFFFF_FFF0, 0, 0, 0, 0, 32'hF0, 0, 0, 1);
    tbl[5]  = mk(0, 1, OpAlu, 32'hF0, 32'h8, 0, 1, 0,            0, 32'hF4, 0, 0, 1);
    tbl[6]  = mk(0, 1, OpJalr, 32'h300, 32'h4, 32'h2001, 0, 0,   1, 32'h2004, 0, 0, 2);
    tbl[7]  = mk(0, 1, OpJalr, 32'h40, 32'h0, 32'h2002, 0, 0,    1, 32'h44, 1, 1, 2);
    tbl[8]  = mk(0, 1, OpJal, 32'h500, 32'h8, 0, 0, 0,           0, 32'h44, 1, 1, 2);
    tbl[9]  = mk(0, 0, OpNop, 0, 0, 0, 0, 1,                     0, 32'h44, 0, 1, 2);
    tbl[10] = mk(0, 0, OpNop, 0, 0, 0, 0, 0,                     0, 32'h48, 0, 1, 2);
    tbl[11] = mk(0, 1, OpSystem, 32'h80, 0, 0, 0, 0,             1, 32'h84, 1, 1, 2);
    tbl[12] = mk(1, 1, OpJal, 32'h600, 32'h20, 0, 0, 0,          0, 32'h84, 1, 1, 2);
    tbl[13] = mk(0, 0, OpNop, 0, 0, 0, 0, 1,                     0, 32'h84, 0, 1, 2);
    tbl[14] = mk(0, 0, OpNop, 0, 0, 0, 0, 0,                     0, 32'h88, 0, 1, 2);
    tbl[15] = mk(0, 1, OpJal, 32'h88, 32'h10, 0, 0, 0,           1, 32'h98, 0, 1, 3);
    tbl[16] = mk(1, 0, OpNop, 0, 0, 0, 0, 0,                     0, 32'h98, 0, 1, 3);
    tbl[17] = mk(0, 0, OpNop, 0, 0, 0, 0, 1,                     0, 32'h9C, 0, 1, 3);
    tbl[18] = mk(0, 0, OpJal, 32'h9C, 32'h40, 0, 0, 0,           0, 32'hA0, 0, 1, 3);
    tbl[19] = mk(0, 1, OpJal, 32'hA0, 32'hFFFF_FF5C, 0, 0, 0,    1, 32'hFFFF_FFFC, 0, 1, 4);
    tbl[20] = mk(0, 0, OpNop, 0, 0, 0, 0, 0,                     0, 32'h0, 0, 1, 4);

    drive(idle);
    rst_n = 1'b0;
    #12;
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_if_valid", {31'd0, if_valid_o}, 32'd1);
    chk("reset_halted", {31'd0, halted_o}, 32'd0);
    chk("reset_misalign", {31'd0, misalign_o}, 32'd0);
    chk("reset_cnt", redirect_cnt_o, 32'd0);
    chk("reset_flush", {31'd0, flush_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Reset released between edges: the first edge after release fetches from 4.
    chk("first_pc", pc_o, 32'h0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i]);
    end

    // Halt via ecall, then pull reset low between edges.
    step(mk(0, 1, OpSystem, 32'h200, 0, 0, 0, 0, 1, 32'h204, 1, 1, 4));
    drive(idle);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc_o, 32'h0);
    chk("async_if_valid", {31'd0, if_valid_o}, 32'd1);
    chk("async_halted", {31'd0, halted_o}, 32'd0);
    chk("async_misalign", {31'd0, misalign_o}, 32'd0);
    chk("async_cnt", redirect_cnt_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      vec_t        v;
      logic        e_flush;
      int unsigned sel;
      logic [31:0] r;
      sel = $urandom_range(0, 9);
      unique case (sel)
        0, 1:    v.op = OpBranch;
        2:       v.op = OpJal;
        3:       v.op = OpJalr;
        4:       v.op = OpSystem;
        default: v.op = 7'($urandom);
      endcase
      v.stall  = ($urandom_range(0, 2) == 0);
      v.valid  = ($urandom_range(0, 3) != 0);
      v.pc     = $urandom & 32'hFFFF_FFFC;
      r        = $urandom;
      v.imm    = ($urandom_range(0, 3) == 0) ? r : (r & 32'hFFFF_FFFC);
      r        = $urandom;
      v.rs1    = ($urandom_range(0, 2) == 0) ? r : (r & 32'hFFFF_FFFC);
      v.tkn    = 1'($urandom);
      v.resume = ($urandom_range(0, 3) == 0);
      e_flush  = model_step(v);
      v.e_flush = e_flush;
      v.e_pc    = m_pc;
      v.e_halt  = m_halted;
      v.e_mis   = m_mis;
      v.e_cnt   = m_cnt;
      step(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side control block of the MineCPU core: owns the program counter and sequences the front end. Each cycle it picks the next fetch address from the sequential PC, a stall hold, or a control-transfer target resolved in EX from the sign-extended immediate produced upstream by the immediate generator. It also flushes wrong-path instructions and runs a RUN/HALT state machine for `ecall` and misaligned-target traps. It sits between the EX stage and instruction memory.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `stall_i`  in  1  hazard stall; holds PC while asserted.
- `ex_valid_i`  in  1  EX holds a real instruction, not a bubble.
- `ex_opcode_i`  in  7  inst[6:0] of the EX instruction.
- `ex_pc_i`  in  32  PC of the EX instruction.
- `ex_imm_i`  in  32  sign-extended immediate of the EX instruction.
- `ex_rs1_i`  in  32  forwarded rs1 value.
- `ex_br_taken_i`  in  1  branch comparison result; meaningful only for BRANCH.
- `resume_i`  in  1  single-cycle pulse that leaves HALT.
- `pc_o`  out  32  current fetch address (registered).
- `if_valid_o`  out  1  fetch slot valid (registered); 0 in HALT.
- `flush_o`  out  1  kills IF/ID and ID/EX contents (combinational).
- `link_o`  out  32  ex_pc_i + 4 (combinational); JAL/JALR writeback value.
- `halted_o`  out  1  state == HALT.
- `misalign_o`  out  1  sticky misaligned-target flag.
- `redirect_cnt_o`  out  32  count of taken redirects; wraps.

## Operation
- Opcodes decoded:
  - BRANCH 1100011
  - JAL 1101111
  - JALR 1100111
  - SYSTEM 1110011
- Target computation (32-bit, carries discarded):
  - BRANCH and JAL: ex_pc_i + ex_imm_i.
  - JALR: (ex_rs1_i + ex_imm_i) & ~32'h1.
- `redirect_req` = ex_valid_i & (JAL | JALR | (BRANCH & ex_br_taken_i)).
- `trap_req` = ex_valid_i & (SYSTEM | (redirect_req & target[1])).
- RUN state, next PC by priority (highest first):
  1. trap_req: pc_o ← ex_pc_i + 4; go to HALT; set misalign_o if the cause is a misaligned target. No redirect, no count.
  2. redirect_req: pc_o ← target; redirect_cnt_o += 1.
  3. stall_i: pc_o holds.
  4. Otherwise: pc_o ← pc_o + 4.
- flush_o = state==RUN & (redirect_req | trap_req).
- Redirects and traps override stall_i.
- HALT state:
  - pc_o holds; if_valid_o = 0; flush_o = 0.
  - ex_valid_i, stall_i and redirect requests are ignored.
  - resume_i → RUN at next edge, if_valid_o = 1; fetch restarts at the held pc_o.
  - resume_i in RUN is ignored.
- misalign_o clears only on reset.
- Non-control opcodes in EX never affect the PC.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - pc_o = RESET_PC, if_valid_o = 1, state = RUN.
  - halted_o = 0, misalign_o = 0, redirect_cnt_o = 0.
  - Reset mid-HALT or mid-redirect discards all pending work.
- Redirect resolved in cycle t (EX):
  - flush_o high in cycle t.
  - pc_o = target at t+1.
  - Penalty: 2 wrong-path slots, namely the instructions in IF and ID at cycle t.
- Trap in cycle t:
  - flush_o high in cycle t.
  - halted_o = 1, if_valid_o = 0 and pc_o = ex_pc_i + 4 at t+1.
- resume_i at cycle t in HALT: halted_o = 0 and if_valid_o = 1 at t+1.
- Stall: pc_o is unchanged on every edge where stall_i is high and no redirect or trap is requested.
- Counter wrap: 32'hFFFF_FFFF + 1 → 0.
- PC wrap: 32'hFFFF_FFFC + 4 → 0.

## Test plan
- Reset and sequential fetch: RESET_PC = 0, reset released, no EX activity → pc_o = 0, 4, 8, 12 on successive cycles; if_valid_o = 1; flush_o = 0.
- Taken branch beating stall: ex_pc_i = 0x100, ex_imm_i = 0xFFFFFFF0, BRANCH, taken, stall_i = 1 → flush_o = 1 that cycle, next pc_o = 0xF0, redirect_cnt_o = 1. Same case not taken with stall_i = 1 → pc_o holds.
- JALR bit-0 clear and link value: ex_rs1_i = 0x2001, ex_imm_i = 4 → next pc_o = 0x2004; link_o = ex_pc_i + 4.
- JALR misaligned target: ex_rs1_i = 0x2002, ex_imm_i = 0, ex_pc_i = 0x40 → flush_o = 1, then halted_o = 1, misalign_o = 1, pc_o = 0x44, redirect_cnt_o unchanged.
- ecall and resume: SYSTEM at ex_pc_i = 0x80 → HALT with pc_o = 0x84. While halted, a JAL in EX is ignored. resume_i pulse → RUN; pc_o = 0x84, then 0x88.
- Asynchronous reset during HALT: rst_n low between clock edges → all outputs at reset values immediately; misalign_o = 0.
